// File: rtl/ame_pri_seq.sv
// ame_pri_seq
//   Sequential nearest-power-of-two rounder for wide operands in the AME
//   path. It captures an operand plus an increment carry, then scans the
//   operand one byte per cycle from MSB to LSB looking for the leading one.
//   The result is rounded half-up to a power of two. The round-up carry-out
//   convention matches the 8-bit priority slices.
//
// Ports
//   clk_i        clock
//   rst_n_i      asynchronous active-low reset
//   in_valid_i   operand valid
//   in_ready_o   block can accept an operand (high only in IDLE)
//   in_data_i    operand, DATA_WIDTH bits
//   in_carry_i   +1 added to the operand at capture
//   out_valid_o  result valid (high only in DONE)
//   out_ready_i  downstream accepts the result
//   out_data_o   rounded power of two (one-hot or zero)
//   out_carry_o  rounding overflowed past bit DATA_WIDTH-1
//   out_exp_o    exponent of the result; present only when
//                AME_PRI_SEQ_EXP_EN is defined
//
// Parameters
//   DATA_WIDTH   operand/result width; multiple of 8, at least 16
//
// Optional feature macro: AME_PRI_SEQ_EXP_EN
module ame_pri_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_carry_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
`ifdef AME_PRI_SEQ_EXP_EN
  output logic [$clog2(DATA_WIDTH):0] out_exp_o,
`endif
  output logic                  out_carry_o
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = $clog2(NB);
  localparam int KW = IW + 3;
  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] MSB_ONLY = ONE << (DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH:0]   op_q, op_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  carry_q, carry_d;
`ifdef AME_PRI_SEQ_EXP_EN
  logic [KW:0]           exp_q, exp_d;
`endif

  logic [7:0]    byte_sel;
  logic [2:0]    lead_pos;
  logic [KW-1:0] lead_k;
  logic [KW-1:0] lead_k_m1;
  logic          below_bit;

  // Leading-one search inside the current byte. Every byte above idx has
  // already been found to be zero, so the leading one of the whole operand
  // is {idx, position-in-byte}. The rounding bit sits just below it and may
  // live in the next lower byte, so it is read from the full register.
  always_comb begin
    byte_sel = op_q[int'(idx_q)*8 +: 8];
    lead_pos = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (byte_sel[i]) lead_pos = 3'(i);
    end
    lead_k    = {idx_q, lead_pos};
    lead_k_m1 = lead_k - KW'(1);
    below_bit = (lead_k == '0) ? 1'b0 : op_q[lead_k_m1];
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    data_d  = data_q;
    carry_d = carry_q;
`ifdef AME_PRI_SEQ_EXP_EN
    exp_d   = exp_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          op_d    = {1'b0, in_data_i} + (DATA_WIDTH+1)'(in_carry_i);
          idx_d   = IW'(NB - 1);
          state_d = SCAN;
        end
      end
      SCAN: begin
        // Overflow covers both the increment carrying out of the operand
        // and a round-up from the top bit.
        if (op_q[DATA_WIDTH] ||
            (byte_sel != 8'd0 && below_bit && lead_k == KW'(DATA_WIDTH - 1))) begin
          data_d  = MSB_ONLY;
          carry_d = 1'b1;
`ifdef AME_PRI_SEQ_EXP_EN
          exp_d   = (KW+1)'(DATA_WIDTH);
`endif
          state_d = DONE;
        end else if (byte_sel != 8'd0) begin
          carry_d = 1'b0;
          if (below_bit) begin
            data_d = (ONE << lead_k) << 1;
`ifdef AME_PRI_SEQ_EXP_EN
            exp_d  = {1'b0, lead_k} + (KW+1)'(1);
`endif
          end else begin
            data_d = ONE << lead_k;
`ifdef AME_PRI_SEQ_EXP_EN
            exp_d  = {1'b0, lead_k};
`endif
          end
          state_d = DONE;
        end else if (idx_q == '0) begin
          data_d  = '0;
          carry_d = 1'b0;
`ifdef AME_PRI_SEQ_EXP_EN
          exp_d   = '0;
`endif
          state_d = DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      op_q    <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      carry_q <= 1'b0;
`ifdef AME_PRI_SEQ_EXP_EN
      exp_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      carry_q <= carry_d;
`ifdef AME_PRI_SEQ_EXP_EN
      exp_q   <= exp_d;
`endif
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign out_data_o  = data_q;
  assign out_carry_o = carry_q;
`ifdef AME_PRI_SEQ_EXP_EN
  assign out_exp_o   = exp_q;
`endif

endmodule
